johnson_decoder: RTL and testbench

JOHNSON_DECODER -- requirements
Module: johnson_decoder

---
 rtl/johnson_decoder_pkg.sv | 14 +
 rtl/johnson_code_check.sv | 27 ++
 rtl/johnson_decoder.sv | 77 +++++++
 tb/tb_johnson_decoder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/johnson_decoder_pkg.sv
// johnson_decoder_pkg: shared state encoding and index-width helper for the Johnson decoder.
package johnson_decoder_pkg;

    typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_e;

    localparam int N_DEF = 4;

    function automatic int idx_w(input int n);
        return $clog2(2 * n);
    endfunction

    localparam int IDX_W_DEF = idx_w(N_DEF);

endpackage

// File: rtl/johnson_code_check.sv
// johnson_code_check: maps a Johnson code to its state index and flags codes outside the 2N-state ring.
module johnson_code_check
    import johnson_decoder_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0]         code_i,
    output logic [idx_w(N)-1:0]  idx_o,
    output logic                 legal_o
);

    localparam int W = idx_w(N);

    int ones, zeros;

    // Legal codes are a run of ones (MSB=0) or a run of zeros (MSB=1) anchored at the LSB.
    always_comb begin
        ones = 0;
        for (int i = 0; i < N; i++) ones = ones + int'(code_i[i]);
        zeros = N - ones;
        legal_o = 1'b1;
        for (int i = 0; i < N; i++)
            if (code_i[N-1] ? (code_i[i] != (i >= zeros)) : (code_i[i] != (i < ones))) legal_o = 1'b0;
        idx_o = code_i[N-1] ? W'(N + zeros) : W'(ones);
    end

endmodule

// File: rtl/johnson_decoder.sv
// johnson_decoder: decodes a Johnson-coded counter, checks its stepping and tracks lock.
module johnson_decoder
    import johnson_decoder_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int LOCK_CNT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [N-1:0]        in_code,
    output logic                out_valid,
    output logic [idx_w(N)-1:0] count,
    output logic                illegal,
    output logic                seq_err,
    output logic                locked,
    output logic [7:0]          err_cnt
);

    localparam int W = idx_w(N);
    localparam logic [W-1:0] LAST = W'(2 * N - 1);
    localparam logic [3:0] LOCK = 4'(LOCK_CNT);

    logic [W-1:0] idx, ref_q, ref_d, succ;
    logic         legal, hunt, hold, bad_seq, err;
    logic [3:0]   prog_q, prog_d;
    logic [7:0]   err_q, err_d;
    state_e       state_q, state_d;
    logic         out_valid_q, illegal_q, seq_err_q;

    johnson_code_check #(.N(N)) u_check (
        .code_i  (in_code),
        .idx_o   (idx),
        .legal_o (legal)
    );

    // In HUNT there is no trusted reference, so nothing can be a sequence error.
    always_comb begin
        hunt = state_q == HUNT;
        succ = ref_q == LAST ? '0 : ref_q + W'(1);
        hold = !hunt && idx == ref_q;
        bad_seq = legal && !hunt && !hold && idx != succ;
        err = in_valid && (!legal || bad_seq);
        ref_d = in_valid && legal ? idx : ref_q;
        err_d = err && err_q != 8'hff ? err_q + 8'd1 : err_q;
        prog_d = !in_valid ? prog_q : (err || hunt) ? 4'd0 : (state_q == TRACK && !hold) ? prog_q + 4'd1 : prog_q;
        state_d = !in_valid ? state_q : err ? HUNT : hunt ? TRACK : (state_q == TRACK && !hold && prog_d == LOCK) ? LOCKED : state_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= HUNT;
            ref_q       <= '0;
            prog_q      <= '0;
            err_q       <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            prog_q      <= prog_d;
            err_q       <= err_d;
            out_valid_q <= in_valid;
            illegal_q   <= in_valid && !legal;
            seq_err_q   <= in_valid && bad_seq;
        end
    end

    assign out_valid = out_valid_q;
    assign count     = ref_q;
    assign illegal   = illegal_q;
    assign seq_err   = seq_err_q;
    assign locked    = state_q == LOCKED;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// tb_johnson_decoder: directed vector table, saturation run and randomized model check for johnson_decoder.
module tb_johnson_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_code = 4'd0;
    logic       out_valid, illegal, seq_err, locked;
    logic [2:0] count;
    logic [7:0] err_cnt;

    int total = 0;
    int bad = 0;

    johnson_decoder #(.N(4), .LOCK_CNT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_code   (in_code),
        .out_valid (out_valid),
        .count     (count),
        .illegal   (illegal),
        .seq_err   (seq_err),
        .locked    (locked),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {int r, v, c, ov, cnt, ill, se, lk, err;} vec_t;
    vec_t tbl[$];

    // Reference model: Johnson ring as a list of codes, lock as a streak of +1 steps.
    int m_cnt, m_streak, m_err;
    bit m_track, m_lock, e_ov, e_ill, e_se;

    function automatic logic [3:0] jcode(input int k);
        int t;
        t = (k < 4) ? (1 << k) - 1 : (15 << (k - 4));
        return 4'(t & 15);
    endfunction

    function automatic int jidx(input logic [3:0] c);
        for (int k = 0; k < 8; k++) if (c == jcode(k)) return k;
        return -1;
    endfunction

    task automatic model(input bit r, input bit v, input logic [3:0] c);
        int k;
        k = jidx(c);
        e_ill = 0;
        e_se = 0;
        e_ov = r && v;
        if (!r) begin
            m_cnt = 0; m_streak = 0; m_err = 0; m_track = 0; m_lock = 0;
        end else if (v) begin
            if (k < 0) begin
                e_ill = 1; m_track = 0; m_lock = 0;
                if (m_err < 255) m_err++;
            end else if (!m_track) begin
                m_track = 1; m_streak = 0; m_cnt = k;
            end else if (k == (m_cnt + 1) % 8) begin
                m_streak++;
                if (m_streak >= 3) m_lock = 1;
                m_cnt = k;
            end else if (k != m_cnt) begin
                e_se = 1; m_track = 0; m_lock = 0; m_cnt = k;
                if (m_err < 255) m_err++;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit v, input logic [3:0] c);
        rst = r;
        in_valid = v;
        in_code = c;
        @(posedge clk);
        #1;
        model(r, v, c);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int ov, input int cnt, input int ill, input int se, input int lk, input int err);
        chk({tag, ".out_valid"}, int'(out_valid), ov);
        chk({tag, ".count"}, int'(count), cnt);
        chk({tag, ".illegal"}, int'(illegal), ill);
        chk({tag, ".seq_err"}, int'(seq_err), se);
        chk({tag, ".locked"}, int'(locked), lk);
        chk({tag, ".err_cnt"}, int'(err_cnt), err);
    endtask

    initial begin
        //                r  v  code     ov cnt ill se lk err
        tbl.push_back('{0, 0, 'b0000, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 'b0001, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 'b0011, 1, 2, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 'b0111, 1, 3, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 'b1111, 1, 4, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 'b1110, 1, 5, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 'b1100, 1, 6, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 'b1000, 1, 7, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 'b0000, 1, 0, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 'b0001, 1, 1, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 'b0011, 1, 2, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 'b0011, 1, 2, 0, 0, 1, 0});
        tbl.push_back('{1, 0, 'b0000, 0, 2, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 'b0011, 1, 2, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 'b0111, 1, 3, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 'b0101, 1, 3, 1, 0, 0, 1});
        tbl.push_back('{1, 1, 'b1100, 1, 6, 0, 0, 0, 1});
        tbl.push_back('{1, 1, 'b1000, 1, 7, 0, 0, 0, 1});
        tbl.push_back('{1, 1, 'b0000, 1, 0, 0, 0, 0, 1});
        tbl.push_back('{1, 1, 'b0001, 1, 1, 0, 0, 1, 1});
        tbl.push_back('{1, 1, 'b0011, 1, 2, 0, 0, 1, 1});
        tbl.push_back('{1, 1, 'b1111, 1, 4, 0, 1, 0, 2});
        tbl.push_back('{1, 1, 'b1110, 1, 5, 0, 0, 0, 2});
        tbl.push_back('{0, 1, 'b0001, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 'b0000, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 'b0000, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 'b0001, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 'b0011, 1, 2, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 'b0111, 1, 3, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 'b0000, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 'b1100, 1, 6, 0, 0, 0, 0});

        foreach (tbl[i]) begin
            cycle(1'(tbl[i].r), 1'(tbl[i].v), 4'(tbl[i].c));
            chk_all($sformatf("vec%0d", i), tbl[i].ov, tbl[i].cnt, tbl[i].ill, tbl[i].se, tbl[i].lk, tbl[i].err);
        end

        cycle(0, 0, 4'd0);
        for (int i = 1; i <= 300; i++) begin
            cycle(1, 1, 4'b0101);
            chk("sat.illegal", int'(illegal), 1);
            chk("sat.err_cnt", int'(err_cnt), i < 255 ? i : 255);
        end
        cycle(0, 1, 4'b0001);
        chk_all("rst_with_valid", 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 4'd0);
        chk_all("after_rst", 0, 0, 0, 0, 0, 0);

        cycle(0, 0, 4'd0);
        for (int i = 0; i < 3000; i++) begin
            int p;
            bit r, v;
            logic [3:0] c;
            p = int'($urandom_range(99));
            r = $urandom_range(59) != 0;
            v = $urandom_range(3) != 0;
            c = p < 60 ? jcode((m_cnt + 1) % 8) : p < 70 ? jcode(m_cnt) :
                p < 85 ? jcode(int'($urandom_range(7))) : 4'($urandom_range(15));
            cycle(r, v, c);
            chk_all("rand", int'(e_ov), m_cnt, int'(e_ill), int'(e_se), int'(m_lock), m_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
